// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register: operation modes and a helper
// that identifies the modes that advance the word-framing counter.
package shift_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110
    } mode_e;

    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR);
    endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control and data bundle of the universal shift register; the master drives
// mode/data, the slave (the register itself) returns contents and framing.
interface universal_shift_register_if #(
    parameter int WIDTH = 8
);
    import shift_register_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic             en;
    mode_e            mode;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
    logic [CNT_W-1:0] shift_count;
    logic             word_valid;

    modport master (
        output en, mode, serial_in, parallel_in,
        input  parallel_out, serial_out, shift_count, word_valid
    );

    modport slave (
        input  en, mode, serial_in, parallel_in,
        output parallel_out, serial_out, shift_count, word_valid
    );

endinterface

// File: rtl/universal_shift_register_counter.sv
// Word-framing counter: counts shifts into the current word and pulses
// wrap_pulse for one cycle when the WIDTH-th shift lands.
module shift_word_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     wrap_pulse
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // clr wins over inc; the pulse is cleared on any cycle that does not complete a word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                if (count == LAST) begin
                    count      <= '0;
                    wrap_pulse <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: shift, rotate, load and clear per
// cycle, with a registered serial output and word-framing via shift_word_counter.
module universal_shift_register
    import shift_register_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    universal_shift_register_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] q;
    logic             serial_q;
    logic [CNT_W-1:0] count;
    logic             wrap_pulse;
    logic             cnt_inc;
    logic             cnt_clr;

    // Rotates, loads and holds leave serial_out untouched; only true shifts and CLEAR change it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q        <= RESET_VALUE;
            serial_q <= 1'b0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHL: begin
                    q        <= {q[WIDTH-2:0], bus.serial_in};
                    serial_q <= q[WIDTH-1];
                end
                MODE_SHR: begin
                    q        <= {bus.serial_in, q[WIDTH-1:1]};
                    serial_q <= q[0];
                end
                MODE_ROL:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:   q <= {q[0], q[WIDTH-1:1]};
                MODE_LOAD:  q <= bus.parallel_in;
                MODE_CLEAR: begin
                    q        <= RESET_VALUE;
                    serial_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (bus.en) begin
            cnt_inc = is_shift(bus.mode);
            cnt_clr = (bus.mode == MODE_LOAD) || (bus.mode == MODE_CLEAR);
        end
    end

    shift_word_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (cnt_inc),
        .clr        (cnt_clr),
        .count      (count),
        .wrap_pulse (wrap_pulse)
    );

    assign bus.parallel_out = q;
    assign bus.serial_out   = serial_q;
    assign bus.shift_count  = count;
    assign bus.word_valid   = wrap_pulse;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: an 8-bit default instance and a
// 4-bit instance with RESET_VALUE=4'hF, checked against hand-computed vectors.
module tb_universal_shift_register;
    import shift_register_pkg::*;

    logic clk = 1'b0;
    logic rst8_n;
    logic rst4_n;
    int   errors = 0;
    int   checks = 0;
    int   pulses;

    universal_shift_register_if #(.WIDTH(8)) bus8 ();
    universal_shift_register_if #(.WIDTH(4)) bus4 ();

    universal_shift_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (bus8.slave)
    );

    universal_shift_register #(
        .WIDTH       (4),
        .RESET_VALUE (4'hF)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the 8-bit instance for one edge, then settle #1 past the edge
    task automatic applyStimulus(input mode_e m, input logic sin, input logic [7:0] pin,
                                 input logic e, input logic rn);
        bus8.mode        = m;
        bus8.serial_in   = sin;
        bus8.parallel_in = pin;
        bus8.en          = e;
        rst8_n           = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus4(input mode_e m, input logic sin, input logic [3:0] pin);
        bus4.mode        = m;
        bus4.serial_in   = sin;
        bus4.parallel_in = pin;
        bus4.en          = 1'b1;
        rst4_n           = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pattern;
        pattern = 8'b1011_0011;

        bus4.mode = MODE_HOLD; bus4.serial_in = 1'b0; bus4.parallel_in = '0;
        bus4.en = 1'b0; rst4_n = 1'b0;
        #1;

        // Reset both instances on one edge
        applyStimulus(MODE_HOLD, 1'b0, 8'h00, 1'b0, 1'b0);
        rst4_n = 1'b1;
        checkOutput("rst_po", bus8.parallel_out, 8'h00);
        checkOutput("rst_so", bus8.serial_out, 1'b0);
        checkOutput("rst_cnt", bus8.shift_count, 3'd0);
        checkOutput("rst_wv", bus8.word_valid, 1'b0);
        checkOutput("rst4_po", bus4.parallel_out, 4'hF);

        // SHL framing, MSB first
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(MODE_SHL, pattern[i], 8'h00, 1'b1, 1'b1);
            if (i == 1) begin
                checkOutput("shl7_cnt", bus8.shift_count, 3'd7);
                checkOutput("shl7_wv", bus8.word_valid, 1'b0);
            end
        end
        checkOutput("shl_po", bus8.parallel_out, 8'hB3);
        checkOutput("shl_wv", bus8.word_valid, 1'b1);
        checkOutput("shl_cnt", bus8.shift_count, 3'd0);
        checkOutput("shl_so", bus8.serial_out, 1'b0);
        applyStimulus(MODE_HOLD, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("hold_wv", bus8.word_valid, 1'b0);
        checkOutput("hold_po", bus8.parallel_out, 8'hB3);

        // Rotates
        applyStimulus(MODE_ROL, 1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("rol_po", bus8.parallel_out, 8'h67);
        applyStimulus(MODE_ROR, 1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("ror1_po", bus8.parallel_out, 8'hB3);
        applyStimulus(MODE_ROR, 1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("ror2_po", bus8.parallel_out, 8'hD9);
        checkOutput("rot_so", bus8.serial_out, 1'b0);
        checkOutput("rot_cnt", bus8.shift_count, 3'd0);
        checkOutput("rot_wv", bus8.word_valid, 1'b0);

        // LOAD then SHR
        applyStimulus(MODE_LOAD, 1'b0, 8'hB3, 1'b1, 1'b1);
        checkOutput("load_po", bus8.parallel_out, 8'hB3);
        applyStimulus(MODE_SHR, 1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("shr_po", bus8.parallel_out, 8'hD9);
        checkOutput("shr_so", bus8.serial_out, 1'b1);
        checkOutput("shr_cnt", bus8.shift_count, 3'd1);
        applyStimulus(MODE_ROL, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("rol2_po", bus8.parallel_out, 8'hB3);
        checkOutput("rol2_so", bus8.serial_out, 1'b1);
        checkOutput("rol2_cnt", bus8.shift_count, 3'd1);

        // Three SHL of 0: B3 -> 66 -> CC -> 98
        for (int i = 0; i < 3; i++) applyStimulus(MODE_SHL, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("mid_po", bus8.parallel_out, 8'h98);
        checkOutput("mid_cnt", bus8.shift_count, 3'd4);
        checkOutput("mid_so", bus8.serial_out, 1'b1);
        applyStimulus(MODE_LOAD, 1'b0, 8'h5A, 1'b1, 1'b1);
        checkOutput("ldmid_po", bus8.parallel_out, 8'h5A);
        checkOutput("ldmid_cnt", bus8.shift_count, 3'd0);
        checkOutput("ldmid_so", bus8.serial_out, 1'b1);

        // Enable low holds everything even with SHL requested
        for (int i = 0; i < 4; i++) applyStimulus(MODE_SHL, 1'b1, 8'h00, 1'b0, 1'b1);
        checkOutput("en0_po", bus8.parallel_out, 8'h5A);
        checkOutput("en0_cnt", bus8.shift_count, 3'd0);
        checkOutput("en0_so", bus8.serial_out, 1'b1);
        checkOutput("en0_wv", bus8.word_valid, 1'b0);

        // Eight SHL of 0 from 5A: exactly one pulse, on the 8th edge
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(MODE_SHL, 1'b0, 8'h00, 1'b1, 1'b1);
            pulses += int'(bus8.word_valid);
        end
        checkOutput("w1_wv", bus8.word_valid, 1'b1);
        checkOutput("w1_po", bus8.parallel_out, 8'h00);
        checkOutput("w1_so", bus8.serial_out, 1'b0);

        // Back-to-back word mixing directions: 0F after 4 SHL, then 87,C3,E1,F0
        for (int i = 0; i < 4; i++) begin
            applyStimulus(MODE_SHL, 1'b1, 8'h00, 1'b1, 1'b1);
            pulses += int'(bus8.word_valid);
        end
        checkOutput("w2_half_po", bus8.parallel_out, 8'h0F);
        checkOutput("w2_half_cnt", bus8.shift_count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(MODE_SHR, 1'b1, 8'h00, 1'b1, 1'b1);
            pulses += int'(bus8.word_valid);
        end
        checkOutput("w2_po", bus8.parallel_out, 8'hF0);
        checkOutput("w2_wv", bus8.word_valid, 1'b1);
        checkOutput("w2_so", bus8.serial_out, 1'b1);
        checkOutput("pulse_count", pulses, 2);

        // Reserved mode 111 behaves as HOLD
        applyStimulus(mode_e'(3'b111), 1'b1, 8'hFF, 1'b1, 1'b1);
        checkOutput("rsv_po", bus8.parallel_out, 8'hF0);
        checkOutput("rsv_wv", bus8.word_valid, 1'b0);
        checkOutput("rsv_cnt", bus8.shift_count, 3'd0);

        // Reset after 5 SHL discards the partial word
        for (int i = 0; i < 5; i++) applyStimulus(MODE_SHL, 1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("pre_rst_po", bus8.parallel_out, 8'h1F);
        checkOutput("pre_rst_cnt", bus8.shift_count, 3'd5);
        applyStimulus(MODE_SHL, 1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput("mrst_po", bus8.parallel_out, 8'h00);
        checkOutput("mrst_so", bus8.serial_out, 1'b0);
        checkOutput("mrst_cnt", bus8.shift_count, 3'd0);
        checkOutput("mrst_wv", bus8.word_valid, 1'b0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(MODE_SHL, 1'b1, 8'h00, 1'b1, 1'b1);
            pulses += int'(bus8.word_valid);
        end
        checkOutput("post_rst_cnt", bus8.shift_count, 3'd3);
        checkOutput("post_rst_pulses", pulses, 0);
        checkOutput("post_rst_po", bus8.parallel_out, 8'h07);
        applyStimulus(MODE_HOLD, 1'b0, 8'h00, 1'b0, 1'b1);

        // WIDTH=4 instance: LOAD 5, SHL 0 twice -> A, 4; CLEAR -> F; 4 SHL of 0 -> 0
        applyStimulus4(MODE_LOAD, 1'b0, 4'h5);
        applyStimulus4(MODE_SHL, 1'b0, 4'h0);
        applyStimulus4(MODE_SHL, 1'b0, 4'h0);
        checkOutput("w4_po", bus4.parallel_out, 4'h4);
        checkOutput("w4_so", bus4.serial_out, 1'b1);
        checkOutput("w4_cnt", bus4.shift_count, 2'd2);
        applyStimulus4(MODE_CLEAR, 1'b0, 4'h0);
        checkOutput("w4_clr_po", bus4.parallel_out, 4'hF);
        checkOutput("w4_clr_so", bus4.serial_out, 1'b0);
        checkOutput("w4_clr_cnt", bus4.shift_count, 2'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus4(MODE_SHL, 1'b0, 4'h0);
            pulses += int'(bus4.word_valid);
        end
        checkOutput("w4_shl_po", bus4.parallel_out, 4'h0);
        checkOutput("w4_shl_wv", bus4.word_valid, 1'b1);
        checkOutput("w4_shl_cnt", bus4.shift_count, 2'd0);
        checkOutput("w4_shl_so", bus4.serial_out, 1'b1);
        checkOutput("w4_pulses", pulses, 1);
        applyStimulus4(MODE_HOLD, 1'b0, 4'h0);
        checkOutput("w4_wv_drop", bus4.word_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
